// File: rtl/fifo_word_serializer.sv
// Pops wide words from a valid-yumi FIFO port and streams them LSB-first as
// narrow valid-ready beats, flagging the final beat of each word with last_o.
module fifo_word_serializer #(
    parameter int unsigned IN_WIDTH_P  = 32,
    parameter int unsigned OUT_WIDTH_P = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   valid_i,
    input  logic [IN_WIDTH_P-1:0]  data_i,
    output logic                   yumi_o,
    output logic                   valid_o,
    output logic [OUT_WIDTH_P-1:0] data_o,
    output logic                   last_o,
    input  logic                   ready_i
);

    localparam int unsigned BEATS = IN_WIDTH_P / OUT_WIDTH_P;
    localparam int unsigned CNT_W = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_n;
    logic [IN_WIDTH_P-1:0] word_r;
    logic [IN_WIDTH_P-1:0] word_n;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_n;
    logic                  is_last;
    logic                  beat_xfer;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            word_r  <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            word_r  <= word_n;
            cnt_r   <= cnt_n;
        end
    end

    assign valid_o   = (state_r == SEND);
    assign is_last   = (cnt_r == LAST_CNT);
    assign last_o    = valid_o & is_last;
    assign beat_xfer = valid_o & ready_i;

    // Beat select: constant-index mux over the held word
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (cnt_r == CNT_W'(i)) begin
                data_o = word_r[i*OUT_WIDTH_P +: OUT_WIDTH_P];
            end
        end
    end

    // Next state and pop; yumi_o is gated by reset since IDLE is the reset state
    always_comb begin
        state_n = state_r;
        word_n  = word_r;
        cnt_n   = cnt_r;
        yumi_o  = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_i) begin
                    yumi_o  = reset_n_i;
                    word_n  = data_i;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (beat_xfer) begin
                    if (!is_last) begin
                        cnt_n = cnt_r + CNT_W'(1);
                    end else if (valid_i) begin
                        yumi_o = reset_n_i;
                        word_n = data_i;
                        cnt_n  = '0;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed self-checking bench for fifo_word_serializer (32-bit words, 8-bit beats).
module tb_fifo_word_serializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        yumi;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        last;
    logic        ready = 1'b0;

    int errors = 0;
    int checks = 0;

    fifo_word_serializer #(
        .IN_WIDTH_P (32),
        .OUT_WIDTH_P(8)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .valid_i  (valid),
        .data_i   (data_in),
        .yumi_o   (yumi),
        .valid_o  (valid_out),
        .data_o   (data_out),
        .last_o   (last),
        .ready_i  (ready)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        // held in reset from time 0 with valid asserted
        valid   = 1'b1;
        data_in = 32'hDDCCBBAA;
        ready   = 1'b1;
        #1;
        checks++; if (yumi !== 1'b0) begin errors++; $display("FAIL reset_init_yumi: got %b expected 0", yumi); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_init_valid: got %b expected 0", valid_out); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_init_last: got %b expected 0", last); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_init_data: got %h expected 00", data_out); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (yumi !== 1'b1) begin errors++; $display("FAIL reset_release_yumi: got %b expected 1", yumi); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            valid = 1'b0;
            ready = 1'b1;
        end
        // park on the last beat with backpressure, then reset mid-cycle
        @(negedge clk);
        valid   = 1'b1;
        data_in = 32'h12345678;
        ready   = 1'b0;
        #1;
        checks++; if (last !== 1'b1 || data_out !== 8'hDD) begin errors++; $display("FAIL reset_pre_last: got last=%b data=%h expected last=1 data=dd", last, data_out); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %b expected 0", valid_out); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_async_last: got %b expected 0", last); end
        checks++; if (yumi !== 1'b0) begin errors++; $display("FAIL reset_async_yumi: got %b expected 0", yumi); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_async_data: got %h expected 00", data_out); end
        @(negedge clk);
        reset_n = 1'b1;
        valid   = 1'b0;
        ready   = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] w = 32'hDDCCBBAA;
        logic        exp_yumi, exp_valid, exp_last;
        logic [7:0]  exp_data;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            valid   = (k == 0);
            data_in = (k == 0) ? w : 32'h0;
            ready   = 1'b1;
            #1;
            exp_yumi  = (k == 0);
            exp_valid = (k >= 1 && k <= 4);
            exp_last  = (k == 4);
            checks++; if (yumi !== exp_yumi) begin errors++; $display("FAIL single_yumi c%0d: got %b expected %b", k, yumi, exp_yumi); end
            checks++; if (valid_out !== exp_valid) begin errors++; $display("FAIL single_valid c%0d: got %b expected %b", k, valid_out, exp_valid); end
            checks++; if (last !== exp_last) begin errors++; $display("FAIL single_last c%0d: got %b expected %b", k, last, exp_last); end
            if (exp_valid) begin
                exp_data = 8'(w >> (8 * (k - 1)));
                checks++; if (data_out !== exp_data) begin errors++; $display("FAIL single_data c%0d: got %h expected %h", k, data_out, exp_data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2];
        int          idx = 0;
        logic        exp_yumi, exp_valid, exp_last;
        logic [7:0]  exp_data;
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            valid   = (idx < 2);
            data_in = (idx < 2) ? words[idx] : 32'h0;
            ready   = 1'b1;
            #1;
            exp_yumi  = (k == 0 || k == 4);
            exp_valid = (k >= 1 && k <= 8);
            exp_last  = (k == 4 || k == 8);
            checks++; if (yumi !== exp_yumi) begin errors++; $display("FAIL b2b_yumi c%0d: got %b expected %b", k, yumi, exp_yumi); end
            checks++; if (valid_out !== exp_valid) begin errors++; $display("FAIL b2b_valid c%0d: got %b expected %b", k, valid_out, exp_valid); end
            checks++; if (last !== exp_last) begin errors++; $display("FAIL b2b_last c%0d: got %b expected %b", k, last, exp_last); end
            if (exp_valid) begin
                exp_data = 8'(k - 1);
                checks++; if (data_out !== exp_data) begin errors++; $display("FAIL b2b_data c%0d: got %h expected %h", k, data_out, exp_data); end
            end
            if (exp_yumi) idx++;
        end
    endtask

    task automatic test_backpressure();
        logic        exp_yumi, exp_valid, exp_last;
        logic [7:0]  exp_data;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            valid   = (k == 0) || (k >= 2 && k <= 4);
            data_in = (k == 0) ? 32'hDDCCBBAA : 32'h5A5A5A5A;
            ready   = !(k >= 2 && k <= 4);
            #1;
            exp_yumi  = (k == 0);
            exp_valid = (k >= 1 && k <= 7);
            exp_last  = (k == 7);
            case (k)
                1:       exp_data = 8'hAA;
                6:       exp_data = 8'hCC;
                7:       exp_data = 8'hDD;
                default: exp_data = 8'hBB;
            endcase
            checks++; if (yumi !== exp_yumi) begin errors++; $display("FAIL bp_yumi c%0d: got %b expected %b", k, yumi, exp_yumi); end
            checks++; if (valid_out !== exp_valid) begin errors++; $display("FAIL bp_valid c%0d: got %b expected %b", k, valid_out, exp_valid); end
            checks++; if (last !== exp_last) begin errors++; $display("FAIL bp_last c%0d: got %b expected %b", k, last, exp_last); end
            if (exp_valid) begin
                checks++; if (data_out !== exp_data) begin errors++; $display("FAIL bp_data c%0d: got %h expected %h", k, data_out, exp_data); end
            end
        end
    endtask

    task automatic test_early_valid();
        logic        exp_yumi, exp_valid, exp_last;
        logic [7:0]  exp_data;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            valid   = (k <= 5);
            data_in = (k == 0) ? 32'hDDCCBBAA : 32'h88776655;
            ready   = (k != 4);
            #1;
            exp_yumi  = (k == 0 || k == 5);
            exp_valid = (k >= 1 && k <= 9);
            exp_last  = (k == 4 || k == 5 || k == 9);
            case (k)
                1:       exp_data = 8'hAA;
                2:       exp_data = 8'hBB;
                3:       exp_data = 8'hCC;
                4, 5:    exp_data = 8'hDD;
                6:       exp_data = 8'h55;
                7:       exp_data = 8'h66;
                8:       exp_data = 8'h77;
                default: exp_data = 8'h88;
            endcase
            checks++; if (yumi !== exp_yumi) begin errors++; $display("FAIL early_yumi c%0d: got %b expected %b", k, yumi, exp_yumi); end
            checks++; if (valid_out !== exp_valid) begin errors++; $display("FAIL early_valid c%0d: got %b expected %b", k, valid_out, exp_valid); end
            checks++; if (last !== exp_last) begin errors++; $display("FAIL early_last c%0d: got %b expected %b", k, last, exp_last); end
            if (exp_valid) begin
                checks++; if (data_out !== exp_data) begin errors++; $display("FAIL early_data c%0d: got %h expected %h", k, data_out, exp_data); end
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        valid   = 1'b1;
        data_in = 32'hDDCCBBAA;
        ready   = 1'b1;
        #1;
        checks++; if (yumi !== 1'b1) begin errors++; $display("FAIL midrst_load_yumi: got %b expected 1", yumi); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b1 || data_out !== 8'hCC) begin errors++; $display("FAIL midrst_pre: got valid=%b data=%h expected valid=1 data=cc", valid_out, data_out); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", valid_out); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_after_valid: got %b expected 0", valid_out); end
        @(negedge clk);
        valid   = 1'b1;
        data_in = 32'h44332211;
        #1;
        checks++; if (yumi !== 1'b1) begin errors++; $display("FAIL midrst_next_yumi: got %b expected 1", yumi); end
        @(negedge clk);
        valid = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b1 || data_out !== 8'h11) begin errors++; $display("FAIL midrst_next_beat: got valid=%b data=%h expected valid=1 data=11", valid_out, data_out); end
        for (int k = 0; k < 4; k++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_early_valid();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
